mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch and data-memory requesters of the 5-stage pipeline.
- Sits between the datapath cache interfaces (I-side, D-side) and the RAM model.
- Sequences each access with a grant FSM, holds the grant until the RAM reports ACCESS, and applies data-first priority with a starvation guard for fetch.
- Its iwait/dwait outputs drive the pipeline stall logic upstream of the forwarding and hazard units.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive D grants with iREN pending before I is forced; 1..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iload  out  DATA_W  instruction data returned.
- iwait  out  1  I-side stall; 0 only in the completing cycle.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN and dWEN are never both 1.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dload  out  DATA_W  read data returned.
- dwait  out  1  D-side stall; 0 only in the completing cycle.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- FSM states are IDLE, IGRANT and DGRANT.
- Reset state: IDLE, starvation counter 0.
  - iwait=1, dwait=1, ramREN=0, ramWEN=0.
  - ramaddr, ramstore, iload and dload are all 0.
- IDLE arbitration (registered transition):
  - If dREN or dWEN, go to DGRANT; else if iREN, go to IGRANT.
  - If the counter equals STARVE_MAX and iREN=1, go to IGRANT even when D requests.
- In IGRANT:
  - ramREN=1, ramaddr=iaddr; ramWEN=0.
  - When ramstate==ACCESS: iwait=0 and iload=ramload in that same cycle (combinational pass-through). Next state is IDLE and the counter clears.
- In DGRANT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - When ramstate==ACCESS: dwait=0 and dload=ramload for a read. Next state is IDLE.
  - The counter increments, saturating at STARVE_MAX, if iREN=1 at completion; otherwise it clears.
- The non-granted side always sees wait=1 and load=0.
- Minimum latency is 2 cycles from request to completion (IDLE, then the grant state with ACCESS). Each BUSY cycle adds one.
- Requesters must hold their request, address and store data stable while wait=1.
- Request withdrawn while granted (e.g. branch flush drops iREN): the RAM enables deassert combinationally and the FSM returns to IDLE next cycle. No completion is signalled and the counter is unchanged.
- ramstate==ERROR: the grant is held, enables stay asserted and wait stays 1. This retries until ACCESS or the request is withdrawn.
- Back-to-back: after a completion the FSM always passes through IDLE for one cycle. Each access therefore costs at least 2 cycles, and the bus is never granted to two sides at once.
- RST mid-access: immediately to IDLE and the reset outputs; the in-flight RAM operation is abandoned.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, three extra outputs are added: icount[31:0], dcount[31:0] and stallcount[31:0].
  - icount and dcount increment on each I/D completion.
  - stallcount increments every cycle in which any request is pending and neither side completes.
  - All three are cleared by RST and wrap at 2^32.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- I-only: iREN=1, iaddr=0x40, ramstate ACCESS on the first grant cycle, ramload=0x8C220004 -> iwait=0 exactly in cycle 2, iload=0x8C220004, ramREN=1, ramWEN=0.
- Collision: iREN=1 and dWEN=1 asserted together, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first, ramWEN=1, ramstore=0xDEADBEEF; after D completes, IGRANT follows.
- Starvation: dREN held continuously with iREN=1, STARVE_MAX=4 -> exactly 4 D completions, then an I grant; counter cleared afterwards.
- Latency/error: ramstate sequence BUSY, BUSY, ERROR, ACCESS during DGRANT -> dwait=1 for those cycles, dwait=0 on the ACCESS cycle only.
- Flush: iREN dropped during IGRANT while ramstate=BUSY -> ramREN=0 the same cycle, IDLE next cycle, iwait never 0.
- Reset: RST pulsed mid-DGRANT -> all outputs at reset values asynchronously; with MEM_ARB_PERF_EN, the counters read 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the I/D cache-side requesters and the RAM model.
// The slave modport is the arbiter's view. The master modport is the surrounding environment's view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic [DATA_W-1:0] iload;
   logic              iwait;
   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic [DATA_W-1:0] dload;
   logic              dwait;
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [DATA_W-1:0] ramstore;
   logic [DATA_W-1:0] ramload;
   logic [1:0]        ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the I-fetch and D-memory sides: data-first priority with a fetch starvation guard.
// Defining MEM_ARB_PERF_EN adds the icount/dcount/stallcount performance counters.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input logic           CLK,
   input logic           RST,
   mem_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]   icount,
   output logic [31:0]   dcount,
   output logic [31:0]   stallcount
`endif
);

   typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
   typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t            state_q, state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic              i_done, d_done;
   logic              ram_ren, ram_wen;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_store, i_load, d_load;
   logic              d_req, ram_access;

   assign d_req      = bus.dREN | bus.dWEN;
   assign ram_access = (bus.ramstate == RAM_ACCESS);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      i_done       = 1'b0;
      d_done       = 1'b0;
      ram_ren      = 1'b0;
      ram_wen      = 1'b0;
      ram_addr     = '0;
      ram_store    = '0;
      i_load       = '0;
      d_load       = '0;
      unique case (state_q)
         IDLE: begin
            // A starved fetch overrides data priority once the guard count is reached.
            if (bus.iREN && (starve_cnt_q == STARVE_LIM))
               state_d = IGRANT;
            else if (d_req)
               state_d = DGRANT;
            else if (bus.iREN)
               state_d = IGRANT;
         end
         IGRANT: begin
            if (!bus.iREN) begin
               state_d = IDLE;
            end else begin
               ram_ren  = 1'b1;
               ram_addr = bus.iaddr;
               if (ram_access) begin
                  i_done       = 1'b1;
                  i_load       = bus.ramload;
                  state_d      = IDLE;
                  starve_cnt_d = 4'd0;
               end
            end
         end
         DGRANT: begin
            if (!d_req) begin
               state_d = IDLE;
            end else begin
               ram_ren   = bus.dREN;
               ram_wen   = bus.dWEN;
               ram_addr  = bus.daddr;
               ram_store = bus.dstore;
               if (ram_access) begin
                  d_done  = 1'b1;
                  state_d = IDLE;
                  if (bus.dREN)
                     d_load = bus.ramload;
                  if (!bus.iREN)
                     starve_cnt_d = 4'd0;
                  else if (starve_cnt_q != STARVE_LIM)
                     starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ramREN   = ram_ren;
   assign bus.ramWEN   = ram_wen;
   assign bus.ramaddr  = ram_addr;
   assign bus.ramstore = ram_store;
   assign bus.iload    = i_load;
   assign bus.dload    = d_load;
   assign bus.iwait    = ~i_done;
   assign bus.dwait    = ~d_done;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] icount_q, icount_d, dcount_q, dcount_d, stallcount_q, stallcount_d;

   always_comb begin
      icount_d     = icount_q + {31'd0, i_done};
      dcount_d     = dcount_q + {31'd0, d_done};
      stallcount_d = stallcount_q;
      if ((bus.iREN || d_req) && !i_done && !d_done)
         stallcount_d = stallcount_q + 32'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         icount_q     <= 32'd0;
         dcount_q     <= 32'd0;
         stallcount_q <= 32'd0;
      end else begin
         icount_q     <= icount_d;
         dcount_q     <= dcount_d;
         stallcount_q <= stallcount_d;
      end
   end

   assign icount     = icount_q;
   assign dcount     = dcount_q;
   assign stallcount = stallcount_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, single fetch, collision, starvation guard,
// RAM latency/error retry, fetch flush and asynchronous reset during an access.
module tb_mem_arbiter;

   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_BUSY   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ERROR  = 2'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passed = 0;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_EN
   logic [31:0] icount, dcount, stallcount;
`endif

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .CLK        (clk),
      .RST        (rst),
      .bus        (bus.slave)
`ifdef MEM_ARB_PERF_EN
      ,
      .icount     (icount),
      .dcount     (dcount),
      .stallcount (stallcount)
`endif
   );

   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge; inputs are driven there and outputs sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.iREN     = 1'b0;
      bus.iaddr    = '0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = '0;
      bus.dstore   = '0;
      bus.ramload  = '0;
      bus.ramstate = ST_FREE;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.iwait !== 1'b1) $display("FAIL reset_iwait: got %b expected 1", bus.iwait); else passed++;
      checks++; if (bus.dwait !== 1'b1) $display("FAIL reset_dwait: got %b expected 1", bus.dwait); else passed++;
      checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) $display("FAIL reset_enables: got %b expected 00", {bus.ramREN, bus.ramWEN}); else passed++;
      checks++; if (bus.ramaddr !== 32'd0 || bus.ramstore !== 32'd0) $display("FAIL reset_ram_bus: got %h/%h expected 0/0", bus.ramaddr, bus.ramstore); else passed++;
      checks++; if (bus.iload !== 32'd0 || bus.dload !== 32'd0) $display("FAIL reset_loads: got %h/%h expected 0/0", bus.iload, bus.dload); else passed++;
`ifdef MEM_ARB_PERF_EN
      checks++; if ({icount, dcount, stallcount} !== 96'd0) $display("FAIL reset_perf: got %h expected 0", {icount, dcount, stallcount}); else passed++;
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_i_only();
      step();
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = ST_ACCESS; bus.ramload = 32'h8C220004;
      #1;
      checks++; if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) $display("FAIL ionly_cycle1: got iwait=%b ramREN=%b expected 1/0", bus.iwait, bus.ramREN); else passed++;
      step(); #1;
      checks++; if (bus.iwait !== 1'b0) $display("FAIL ionly_iwait: got %b expected 0", bus.iwait); else passed++;
      checks++; if (bus.iload !== 32'h8C220004) $display("FAIL ionly_iload: got %h expected 8c220004", bus.iload); else passed++;
      checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b10 || bus.ramaddr !== 32'h40) $display("FAIL ionly_ram: got en=%b addr=%h expected 10/40", {bus.ramREN, bus.ramWEN}, bus.ramaddr); else passed++;
      checks++; if (bus.dwait !== 1'b1 || bus.dload !== 32'd0) $display("FAIL ionly_dside: got dwait=%b dload=%h expected 1/0", bus.dwait, bus.dload); else passed++;
      step();
      clear_inputs();
   endtask

   task automatic test_collision();
      step();
      bus.iREN = 1'b1; bus.iaddr = 32'h80;
      bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
      bus.ramstate = ST_ACCESS; bus.ramload = 32'h11111111;
      step(); #1;
      checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b01) $display("FAIL coll_d_enables: got %b expected 01", {bus.ramREN, bus.ramWEN}); else passed++;
      checks++; if (bus.ramstore !== 32'hDEADBEEF || bus.ramaddr !== 32'h100) $display("FAIL coll_d_bus: got %h@%h expected deadbeef@100", bus.ramstore, bus.ramaddr); else passed++;
      checks++; if (bus.dwait !== 1'b0 || bus.iwait !== 1'b1) $display("FAIL coll_d_waits: got d=%b i=%b expected 0/1", bus.dwait, bus.iwait); else passed++;
      checks++; if (bus.dload !== 32'd0 || bus.iload !== 32'd0) $display("FAIL coll_d_loads: got %h/%h expected 0/0", bus.dload, bus.iload); else passed++;
      step();
      bus.dWEN = 1'b0; #1;
      checks++; if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) $display("FAIL coll_idle_gap: got iwait=%b ramREN=%b expected 1/0", bus.iwait, bus.ramREN); else passed++;
      step(); #1;
      checks++; if (bus.iwait !== 1'b0 || bus.iload !== 32'h11111111 || bus.ramaddr !== 32'h80) $display("FAIL coll_i_after: got iwait=%b iload=%h addr=%h expected 0/11111111/80", bus.iwait, bus.iload, bus.ramaddr); else passed++;
      step();
      clear_inputs();
   endtask

   task automatic test_starvation();
      int d_before_first;
      int d_between;
      int i_seen;
      int dn;
      logic both_done;
      d_before_first = -1; d_between = -1; i_seen = 0; dn = 0; both_done = 1'b0;
      step();
      bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h200;
      bus.ramstate = ST_ACCESS; bus.ramload = 32'h0000ABCD;
      for (int cyc = 0; cyc < 60 && i_seen < 2; cyc++) begin
         step(); #1;
         if (bus.iwait === 1'b0 && bus.dwait === 1'b0) both_done = 1'b1;
         if (bus.dwait === 1'b0) dn++;
         if (bus.iwait === 1'b0) begin
            if (i_seen == 0) d_before_first = dn; else d_between = dn;
            dn = 0;
            i_seen++;
         end
      end
      checks++; if (d_before_first !== 4) $display("FAIL starve_first: got %0d D completions before I, expected 4", d_before_first); else passed++;
      checks++; if (d_between !== 4) $display("FAIL starve_cleared: got %0d D completions between I grants, expected 4", d_between); else passed++;
      checks++; if (both_done !== 1'b0) $display("FAIL starve_exclusive: got both sides completing in one cycle, expected never"); else passed++;
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_latency_error();
      logic [1:0] seq [4];
      seq[0] = ST_BUSY; seq[1] = ST_BUSY; seq[2] = ST_ERROR; seq[3] = ST_ACCESS;
      bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramload = 32'hCAFEF00D; bus.ramstate = ST_FREE;
      for (int k = 0; k < 4; k++) begin
         step();
         bus.ramstate = seq[k]; #1;
         if (k < 3) begin
            checks++; if (bus.dwait !== 1'b1 || bus.ramREN !== 1'b1) $display("FAIL lat_hold_%0d: got dwait=%b ramREN=%b expected 1/1", k, bus.dwait, bus.ramREN); else passed++;
         end else begin
            checks++; if (bus.dwait !== 1'b0 || bus.dload !== 32'hCAFEF00D) $display("FAIL lat_access: got dwait=%b dload=%h expected 0/cafef00d", bus.dwait, bus.dload); else passed++;
         end
      end
      step();
      clear_inputs(); #1;
      checks++; if (bus.dwait !== 1'b1 || bus.ramREN !== 1'b0) $display("FAIL lat_after: got dwait=%b ramREN=%b expected 1/0", bus.dwait, bus.ramREN); else passed++;
   endtask

   task automatic test_flush();
      step();
      bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = ST_BUSY;
      step(); #1;
      checks++; if (bus.ramREN !== 1'b1 || bus.iwait !== 1'b1) $display("FAIL flush_grant: got ramREN=%b iwait=%b expected 1/1", bus.ramREN, bus.iwait); else passed++;
      step();
      bus.iREN = 1'b0; #1;
      checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) $display("FAIL flush_drop: got ramREN=%b iwait=%b expected 0/1", bus.ramREN, bus.iwait); else passed++;
      step();
      bus.iREN = 1'b1; bus.ramstate = ST_ACCESS; #1;
      checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) $display("FAIL flush_idle: got ramREN=%b iwait=%b expected 0/1", bus.ramREN, bus.iwait); else passed++;
      step(); #1;
      checks++; if (bus.iwait !== 1'b0 || bus.ramaddr !== 32'h500) $display("FAIL flush_regrant: got iwait=%b addr=%h expected 0/500", bus.iwait, bus.ramaddr); else passed++;
      step();
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      step();
      bus.dWEN = 1'b1; bus.daddr = 32'h600; bus.dstore = 32'h12345678; bus.ramstate = ST_BUSY;
      step(); #1;
      checks++; if (bus.ramWEN !== 1'b1 || bus.ramstore !== 32'h12345678) $display("FAIL rstmid_grant: got ramWEN=%b store=%h expected 1/12345678", bus.ramWEN, bus.ramstore); else passed++;
      rst = 1'b1; #1;
      checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00 || bus.ramaddr !== 32'd0 || bus.ramstore !== 32'd0) $display("FAIL rstmid_ram: got en=%b addr=%h store=%h expected 00/0/0", {bus.ramREN, bus.ramWEN}, bus.ramaddr, bus.ramstore); else passed++;
      checks++; if (bus.dwait !== 1'b1 || bus.iwait !== 1'b1) $display("FAIL rstmid_waits: got d=%b i=%b expected 1/1", bus.dwait, bus.iwait); else passed++;
`ifdef MEM_ARB_PERF_EN
      checks++; if ({icount, dcount, stallcount} !== 96'd0) $display("FAIL rstmid_perf: got %h expected 0", {icount, dcount, stallcount}); else passed++;
`endif
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
      step(); #1;
      checks++; if (bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1) $display("FAIL rstmid_after: got ramWEN=%b dwait=%b expected 0/1", bus.ramWEN, bus.dwait); else passed++;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_i_only();
      test_collision();
      test_starvation();
      test_latency_error();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
